// File: rtl/mm_pkg.sv
// Shared constants and types for the 2x3 matrix-multiplier result path.
package mm_pkg;

  localparam int unsigned ROW_W   = 2;
  localparam int unsigned COL_W   = 3;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned LAT_W   = 2;
  localparam int unsigned MM_ROWS = 2;
  localparam int unsigned MM_COLS = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_FIN  = 3'd4
  } scan_state_t;

endpackage

// File: rtl/mm_pix_map.sv
// Product-to-pixel mapping: right shift, saturate to 8 bits, optional threshold.
// Optional feature macro: MM_SCAN_THRESH_EN (binary edge map against thresh).
module mm_pix_map
  import mm_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  logic [PROD_W-1:0] prod,
  input  logic [PIX_W-1:0]  thresh,
  output logic [PIX_W-1:0]  pix_c
);

  logic [PROD_W-1:0] shifted;
  logic [PIX_W-1:0]  sat;

  // Truncating shift, then clamp anything above 8 bits to full scale
  always_comb begin
    shifted = prod >> SHIFT;
    sat     = (shifted > PROD_W'(255)) ? '1 : shifted[PIX_W-1:0];
  end

`ifdef MM_SCAN_THRESH_EN
  assign pix_c = (sat >= thresh) ? '1 : '0;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign pix_c = sat;
`endif

endmodule

// File: rtl/mm_result_scanner.sv
// Walks the multiplier result matrix in row-major order and streams each
// mapped product as a pixel beat with its coordinates.
// Optional feature macro: MM_SCAN_THRESH_EN (see mm_pix_map).
module mm_result_scanner
  import mm_pkg::*;
#(
  parameter int unsigned ROWS     = MM_ROWS,
  parameter int unsigned COLS     = MM_COLS,
  parameter int unsigned READ_LAT = 0,
  parameter int unsigned SHIFT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  thresh,
  output logic [ROW_W-1:0]  row_out,
  output logic [COL_W-1:0]  col_out,
  input  logic [PROD_W-1:0] prod_in,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic [ROW_W-1:0]  pix_row,
  output logic [COL_W-1:0]  pix_col,
  output logic              busy,
  output logic              done
);

  scan_state_t      state_q, state_d;
  logic [ROW_W-1:0] r_q, r_d;
  logic [COL_W-1:0] c_q, c_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [PIX_W-1:0] thresh_q, thresh_d;
  logic [ROW_W-1:0] row_out_d, pix_row_d;
  logic [COL_W-1:0] col_out_d, pix_col_d;
  logic [PIX_W-1:0] pix_data_d, pix_c;
  logic             pix_valid_d, busy_d, done_d, last;

  mm_pix_map #(.SHIFT(SHIFT)) u_map (
    .prod   (prod_in),
    .thresh (thresh_q),
    .pix_c  (pix_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    lat_d       = lat_q;
    thresh_d    = thresh_q;
    row_out_d   = row_out;
    col_out_d   = col_out;
    pix_valid_d = pix_valid;
    pix_data_d  = pix_data;
    pix_row_d   = pix_row;
    pix_col_d   = pix_col;
    busy_d      = busy;
    done_d      = 1'b0;
    last        = (r_q == ROW_W'(ROWS - 1)) && (c_q == COL_W'(COLS - 1));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          thresh_d = thresh;
          r_d      = '0;
          c_d      = '0;
          busy_d   = 1'b1;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        row_out_d = r_q;
        col_out_d = c_q;
        lat_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == LAT_W'(READ_LAT)) begin
          pix_data_d  = pix_c;
          pix_row_d   = r_q;
          pix_col_d   = c_q;
          pix_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          lat_d = LAT_W'(lat_q + 1'b1);
        end
      end
      ST_HOLD: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          if (last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            if (c_q == COL_W'(COLS - 1)) begin
              c_d = '0;
              r_d = ROW_W'(r_q + 1'b1);
            end else begin
              c_d = COL_W'(c_q + 1'b1);
            end
            state_d = ST_ADDR;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      r_q       <= '0;
      c_q       <= '0;
      lat_q     <= '0;
      thresh_q  <= '0;
      row_out   <= '0;
      col_out   <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_row   <= '0;
      pix_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      c_q       <= c_d;
      lat_q     <= lat_d;
      thresh_q  <= thresh_d;
      row_out   <= row_out_d;
      col_out   <= col_out_d;
      pix_valid <= pix_valid_d;
      pix_data  <= pix_data_d;
      pix_row   <= pix_row_d;
      pix_col   <= pix_col_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_mm_result_scanner.sv
// Self-checking bench for mm_result_scanner: three instances
// (READ_LAT/SHIFT = 0/0, 2/4, 0/8) share stimulus and are checked
// against hand-computed per-beat tables and directed corner sequences.
`timescale 1ns/1ps
module tb_mm_result_scanner;
  import mm_pkg::*;

  typedef struct packed {
    logic [1:0] r;
    logic [2:0] c;
    logic [7:0] d;
  } beat_t;

  // m[k][i]: expected saturated pixel of instance k for beat i (before threshold)
  typedef struct {
    int                    mode;
    logic [7:0]            thr;
    logic [2:0][5:0][7:0]  m;
  } vec_t;

`ifdef MM_SCAN_THRESH_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, pix_ready;
  logic [7:0] thresh;
  int         mode = 0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  logic [1:0]  row_o [3];
  logic [2:0]  col_o [3];
  logic [15:0] prod  [3];
  logic        pv    [3];
  logic [7:0]  pd    [3];
  logic [1:0]  pr    [3];
  logic [2:0]  pc    [3];
  logic        busy  [3];
  logic        done  [3];

  beat_t beats [3][64];
  int    nb       [3] = '{0, 0, 0};
  int    done_cnt [3] = '{0, 0, 0};
  int    done_at  [3] = '{0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mm_result_scanner #(
      .ROWS     (MM_ROWS),
      .COLS     (MM_COLS),
      .READ_LAT ((g == 1) ? 2 : 0),
      .SHIFT    ((g == 0) ? 0 : ((g == 1) ? 4 : 8))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .thresh    (thresh),
      .row_out   (row_o[g]),
      .col_out   (col_o[g]),
      .prod_in   (prod[g]),
      .pix_valid (pv[g]),
      .pix_ready (pix_ready),
      .pix_data  (pd[g]),
      .pix_row   (pr[g]),
      .pix_col   (pc[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  // Multiplier result model: 0 -> 16*r+c, 1 -> constant 0x0123, 2 -> threshold table
  function automatic logic [15:0] prod_f(int md, logic [1:0] r, logic [2:0] c);
    logic [15:0] p;
    case (md)
      0: p = {10'd0, r, 4'd0} | {13'd0, c};
      1: p = 16'h0123;
      default: begin
        case ({r, c})
          5'b00_000: p = 16'h003F;
          5'b00_001: p = 16'h0040;
          5'b00_010: p = 16'h0041;
          5'b01_000: p = 16'h00FF;
          5'b01_001: p = 16'h0100;
          default:   p = 16'h0000;
        endcase
      end
    endcase
    return p;
  endfunction

  assign prod[0] = prod_f(mode, row_o[0], col_o[0]);
  assign prod[2] = prod_f(mode, row_o[2], col_o[2]);

  // Two-cycle-latency memory model: garbage until the address has been stable for 2 cycles
  logic [1:0] prev_r = '0;
  logic [2:0] prev_c = '0;
  int         age = 0;
  always @(posedge clk) begin
    if (row_o[1] != prev_r || col_o[1] != prev_c) age <= 0;
    else if (age < 3) age <= age + 1;
    prev_r <= row_o[1];
    prev_c <= col_o[1];
  end
  assign prod[1] = (row_o[1] == prev_r && col_o[1] == prev_c && age >= 1) ?
                   prod_f(mode, row_o[1], col_o[1]) : 16'hFFFF;

  // Beat and done monitor, sampled mid-cycle
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pv[k] === 1'b1 && pix_ready === 1'b1) begin
        if (nb[k] < 64) beats[k][nb[k]] = {pr[k], pc[k], pd[k]};
        nb[k] = nb[k] + 1;
      end
      if (done[k] === 1'b1) begin
        done_cnt[k] = done_cnt[k] + 1;
        done_at[k]  = cyc;
      end
    end
  end

  function automatic logic [7:0] exp_pix(logic [7:0] m, logic [7:0] thr);
    if (!THR_EN) return m;
    return (m >= thr) ? 8'hFF : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input int k, input string tag);
    chk($sformatf("%s u%0d", tag, k),
        {row_o[k], col_o[k], pv[k], pd[k], pr[k], pc[k], busy[k], done[k]}, 32'd0);
  endtask

  task automatic check_scan(input int k, input int base, input logic [5:0][7:0] m,
                            input logic [7:0] thr, input string tag);
    chk($sformatf("%s u%0d beat count", tag, k), nb[k] - base, 6);
    for (int i = 0; i < 6; i++) begin
      beat_t b;
      b = (base + i < 64) ? beats[k][base + i] : '0;
      chk($sformatf("%s u%0d beat %0d", tag, k, i), b,
          {2'(i / 3), 3'(i % 3), exp_pix(m[i], thr)});
    end
  endtask

  task automatic wait_done(input int k, input int dbase, input int limit, input string tag);
    int n = 0;
    while (done_cnt[k] == dbase && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s u%0d done seen", tag, k), done_cnt[k] > dbase, 1);
  endtask

  task automatic wait_valid0(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pv[0] !== 1'b1 && n < 20);
    chk(tag, pv[0], 1'b1);
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1;
    pix_ready = 1'b1;
    @(posedge clk); #1;
    pix_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [3];
    int   base  [3];
    int   dbase [3];
    int   t0;

    // beats listed from beat 5 (1,2) down to beat 0 (0,0)
    vecs[0].mode = 0; vecs[0].thr = 8'h05;
    vecs[0].m[0] = {8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
    vecs[0].m[1] = {8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
    vecs[0].m[2] = '0;
    vecs[1].mode = 1; vecs[1].thr = 8'h80;
    vecs[1].m[0] = {6{8'hFF}};
    vecs[1].m[1] = {6{8'h12}};
    vecs[1].m[2] = {6{8'h01}};
    vecs[2].mode = 2; vecs[2].thr = 8'h40;
    vecs[2].m[0] = {8'h00, 8'hFF, 8'hFF, 8'h41, 8'h40, 8'h3F};
    vecs[2].m[1] = {8'h00, 8'h10, 8'h0F, 8'h04, 8'h04, 8'h03};
    vecs[2].m[2] = {8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

    reset = 1'b1; start = 1'b0; pix_ready = 1'b1; thresh = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_reset_outs(k, "reset state");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Table-driven full scans with pix_ready held high
    for (int v = 0; v < 3; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      mode = vecs[v].mode; thresh = vecs[v].thr; pix_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin base[k] = nb[k]; dbase[k] = done_cnt[k]; end
      start = 1'b1;
      @(negedge clk);
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      thresh = ~vecs[v].thr;
      for (int k = 0; k < 3; k++) wait_done(k, dbase[k], 60, tag);
      for (int k = 0; k < 3; k++)
        chk($sformatf("%s u%0d start-to-done cycles", tag, k), done_at[k] - t0, (k == 1) ? 31 : 19);
      for (int k = 0; k < 3; k++) check_scan(k, base[k], vecs[v].m[k], vecs[v].thr, tag);
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) chk($sformatf("%s u%0d idle busy", tag, k), busy[k], 1'b0);
    end

    // Start pulses while busy and during FIN are ignored
    mode = 0; thresh = 8'h00; pix_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin base[k] = nb[k]; dbase[k] = done_cnt[k]; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      start = (j == 4 || j == 18);
      if (j == 17) chk("startB u0 before FIN {done,busy}", {done[0], busy[0]}, 2'b01);
      if (j == 18) chk("startB u0 FIN {done,busy}", {done[0], busy[0]}, 2'b10);
    end
    start = 1'b0;
    wait_done(1, dbase[1], 40, "startB");
    repeat (10) @(posedge clk);
    #1;
    check_scan(0, base[0], vecs[0].m[0], 8'h00, "startB");
    check_scan(1, base[1], vecs[0].m[1], 8'h00, "startB");
    chk("startB u0 done count", done_cnt[0] - dbase[0], 1);
    chk("startB busy all", {busy[0], busy[1], busy[2]}, 3'b000);

    // Backpressure on beat (0,2): beat and address stay frozen
    mode = 0; thresh = 8'h00; pix_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin base[k] = nb[k]; dbase[k] = done_cnt[k]; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_valid0($sformatf("stall beat %0d valid", i));
      if (i == 2) begin
        for (int s = 0; s < 5; s++) begin
          chk("stall beat hold", {pv[0], pr[0], pc[0], pd[0]},
              {1'b1, 2'd0, 3'd2, exp_pix(8'h02, 8'h00)});
          chk("stall addr hold", {row_o[0], col_o[0]}, {2'd0, 3'd2});
          @(posedge clk); #1;
          @(negedge clk);
        end
      end
      pulse_ready();
    end
    wait_done(0, dbase[0], 40, "stall");
    check_scan(0, base[0], vecs[0].m[0], 8'h00, "stall");
    @(posedge clk); #1;
    pix_ready = 1'b1;
    repeat (60) @(posedge clk);
    #1;

    // Reset while holding beat (1,0): no further beats, no done
    mode = 0; thresh = 8'h00; pix_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin base[k] = nb[k]; dbase[k] = done_cnt[k]; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_valid0($sformatf("abort beat %0d valid", i));
      if (i < 3) pulse_ready();
    end
    chk("abort holding (1,0)", {pv[0], pr[0], pc[0]}, {1'b1, 2'd1, 3'd0});
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_outs(0, "abort reset outputs");
    reset = 1'b0;
    pix_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort u0 done count", done_cnt[0] - dbase[0], 0);
    chk("abort u0 beat count", nb[0] - base[0], 3);
    chk("abort u0 idle {busy,valid}", {busy[0], pv[0]}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
